// File: rtl/dispensar_cambio_pkg.sv
`default_nettype none
// ============================================================================
// dinero_pkg : coin values, datapath width and change-dispenser FSM states
// Revision   : 1.0
// ============================================================================
package dinero_pkg;

  localparam int WIDTH    = 6;
  localparam int VAL_ALTA = 5;
  localparam int VAL_BAJA = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    REQ  = 3'd2,
    REL  = 3'd3,
    FIN  = 3'd4
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/dispensar_cambio_if.sv
`default_nettype none
// ============================================================================
// dispensar_cambio_if : command, coin-mechanism handshake and status bundle
// Revision            : 1.0
// ============================================================================
interface dispensar_cambio_if #(
  parameter int WIDTH = 6
);

  logic             start;
  logic [WIDTH-1:0] monto;
  logic             coin_ack;
  logic             coin_req;
  logic             moneda;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] restante;
  logic [3:0]       stock5;

  modport master (
    output start, monto, coin_ack,
    input  coin_req, moneda, busy, done, restante, stock5
  );

  modport slave (
    input  start, monto, coin_ack,
    output coin_req, moneda, busy, done, restante, stock5
  );

endinterface
`default_nettype wire

// File: rtl/dispensar_cambio_adder.sv
`default_nettype none
// ============================================================================
// adder : WIDTH-bit ripple adder with carry in/out
// Revision : 1.0
// ============================================================================
module adder #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/dispensar_cambio.sv
`default_nettype none
// ============================================================================
// dispensar_cambio : pays a change amount out as coins, 5-unit first, via a
//                    4-phase req/ack handshake with the release mechanism
// Revision         : 1.0
// ============================================================================
module dispensar_cambio #(
  parameter int WIDTH    = dinero_pkg::WIDTH,
  parameter int VAL_ALTA = dinero_pkg::VAL_ALTA,
  parameter int VAL_BAJA = dinero_pkg::VAL_BAJA,
  parameter int STOCK5   = 7
) (
  input  wire               clk,
  input  wire               rst,
  dispensar_cambio_if.slave bus
);

  import dinero_pkg::*;

  localparam logic [WIDTH-1:0] ALTA_W   = WIDTH'(VAL_ALTA);
  localparam logic [WIDTH-1:0] BAJA_W   = WIDTH'(VAL_BAJA);
  localparam logic [3:0]       STOCK5_W = 4'(STOCK5);

  estado_t          state_q, state_d;
  logic [WIDTH-1:0] restante_q, restante_d;
  logic [3:0]       stock5_q, stock5_d;
  logic             coin_req_q, coin_req_d;
  logic             moneda_q, moneda_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] coin_val;
  logic [WIDTH-1:0] resta;
  logic             no_borrow;

  assign coin_val = moneda_q ? ALTA_W : BAJA_W;

  // restante - coin_val computed as restante + ~coin_val + 1
  adder #(.WIDTH(WIDTH)) u_resta (
    .a    (restante_q),
    .b    (~coin_val),
    .cin  (1'b1),
    .sum  (resta),
    .cout (no_borrow)
  );

  always_comb begin
    state_d    = state_q;
    restante_d = restante_q;
    stock5_d   = stock5_q;
    coin_req_d = coin_req_q;
    moneda_d   = moneda_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.monto != '0) begin
            restante_d = bus.monto;
            busy_d     = 1'b1;
            state_d    = SEL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEL: begin
        if (restante_q == '0) begin
          state_d = FIN;
        end else begin
          moneda_d   = (restante_q >= ALTA_W) && (stock5_q != 4'd0);
          coin_req_d = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.coin_ack) begin
          coin_req_d = 1'b0;
          // a borrow cannot occur under the greedy choice; clamp if it ever did
          restante_d = no_borrow ? resta : '0;
          if (moneda_q && stock5_q != 4'd0) begin
            stock5_d = stock5_q - 4'd1;
          end
          state_d = REL;
        end
      end
      REL: begin
        if (!bus.coin_ack) begin
          state_d = SEL;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      restante_q <= '0;
      stock5_q   <= STOCK5_W;
      coin_req_q <= 1'b0;
      moneda_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      restante_q <= restante_d;
      stock5_q   <= stock5_d;
      coin_req_q <= coin_req_d;
      moneda_q   <= moneda_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.coin_req = coin_req_q;
  assign bus.moneda   = moneda_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.restante = restante_q;
  assign bus.stock5   = stock5_q;

endmodule
`default_nettype wire

// File: tb/tb_dispensar_cambio.sv
`default_nettype none
// ============================================================================
// tb_dispensar_cambio : scoreboard bench for the change dispenser
// Revision            : 1.0
// ============================================================================
module tb_dispensar_cambio;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  dispensar_cambio_if #(.WIDTH(6)) bus ();

  dispensar_cambio #(
    .WIDTH    (6),
    .VAL_ALTA (5),
    .VAL_BAJA (1),
    .STOCK5   (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit is_done;
    bit mon;
    int rest;
    int stk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_stock     = 7;
  bit   ack_en      = 1'b1;
  bit   prev_req    = 1'b0;
  int   ack_d       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // greedy payout expectation: coin type plus restante/stock5 seen at request time
  task automatic expect_pay(input int m);
    int   r;
    exp_t e;
    r = m;
    while (r > 0) begin
      e.is_done = 1'b0;
      e.rest    = r;
      e.stk     = m_stock;
      if (r >= 5 && m_stock > 0) begin
        e.mon = 1'b1;
        r -= 5;
        m_stock--;
      end else begin
        e.mon = 1'b0;
        r -= 1;
      end
      exp_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.mon     = 1'b0;
    e.rest    = 0;
    e.stk     = m_stock;
    exp_q.push_back(e);
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.coin_req && !prev_req) begin
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_coin: got moneda %0d restante %0d, required no coin",
                     bus.moneda, bus.restante);
          end else begin
            mon_e = exp_q.pop_front();
            chk("coin_moneda",   32'(bus.moneda),   32'(mon_e.mon));
            chk("coin_restante", 32'(bus.restante), mon_e.rest);
            chk("coin_stock5",   32'(bus.stock5),   mon_e.stk);
            chk("coin_busy",     32'(bus.busy),     1);
          end
        end
        if (bus.done) begin
          if (exp_q.size() == 0 || !exp_q[0].is_done) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1 restante %0d, required no done",
                     bus.restante);
          end else begin
            mon_e = exp_q.pop_front();
            chk("done_restante", 32'(bus.restante), mon_e.rest);
            chk("done_stock5",   32'(bus.stock5),   mon_e.stk);
            chk("done_busy",     32'(bus.busy),     0);
          end
        end
        prev_req = bus.coin_req;
      end else begin
        prev_req = 1'b0;
      end
    end
  end

  // coin mechanism: ack 0-3 cycles after req, release 0-3 cycles after req drops
  initial begin
    bus.coin_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_en && rst && bus.coin_req && !bus.coin_ack) begin
        ack_d = int'($urandom_range(0, 3));
        repeat (ack_d) @(posedge clk);
        if (ack_d > 0) #1;
        bus.coin_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
          if (!bus.coin_req) break;
          @(posedge clk);
          #1;
        end
        ack_d = int'($urandom_range(0, 3));
        repeat (ack_d) @(posedge clk);
        if (ack_d > 0) #1;
        bus.coin_ack = 1'b0;
      end
    end
  end

  task automatic pay(input int m, input bit restart);
    int i;
    @(negedge clk);
    bus.start = 1'b1;
    bus.monto = 6'(m);
    expect_pay(m);
    @(negedge clk);
    bus.start = 1'b0;
    bus.monto = 6'd33;
    if (m != 0) begin
      chk("busy_after_start", 32'(bus.busy),     1);
      chk("req_latency_1",    32'(bus.coin_req), 0);
      @(negedge clk);
      chk("req_latency_2",    32'(bus.coin_req), 1);
    end else begin
      chk("zero_busy",     32'(bus.busy),     0);
      chk("zero_coin_req", 32'(bus.coin_req), 0);
    end
    if (restart) begin
      repeat (6) @(negedge clk);
      bus.start = 1'b1;
      bus.monto = 6'd20;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pay_timeout: got %0d events outstanding for monto %0d, required 0",
               exp_q.size(), m);
      exp_q.delete();
    end
    repeat (3) begin
      @(negedge clk);
      if (m == 0) chk("zero_busy_never", 32'(bus.busy), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.monto = '0;
    repeat (3) @(negedge clk);
    chk("rst_coin_req", 32'(bus.coin_req), 0);
    chk("rst_moneda",   32'(bus.moneda),   0);
    chk("rst_busy",     32'(bus.busy),     0);
    chk("rst_done",     32'(bus.done),     0);
    chk("rst_restante", 32'(bus.restante), 0);
    chk("rst_stock5",   32'(bus.stock5),   7);
    rst = 1'b1;

    pay(12, 1'b0);
    chk("stock5_after_12", 32'(bus.stock5), 5);
    pay(4, 1'b0);
    chk("stock5_after_4", 32'(bus.stock5), 5);
    pay(0, 1'b0);
    pay(9, 1'b1);
    chk("stock5_after_9", 32'(bus.stock5), 4);
    pay(20, 1'b0);
    chk("stock5_drained", 32'(bus.stock5), 0);
    pay(10, 1'b0);
    chk("stock5_still_0", 32'(bus.stock5), 0);

    // abort a payment with reset while a coin is being requested
    ack_en = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.monto = 6'd12;
    expect_pay(12);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.coin_req; i++) @(negedge clk);
    chk("abort_req_before", 32'(bus.coin_req), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_coin_req", 32'(bus.coin_req), 0);
    chk("abort_restante", 32'(bus.restante), 0);
    chk("abort_stock5",   32'(bus.stock5),   7);
    chk("abort_busy",     32'(bus.busy),     0);
    exp_q.delete();
    m_stock = 7;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 0);
    end
    ack_en = 1'b1;

    pay(63, 1'b0);
    chk("stock5_after_63",   32'(bus.stock5),   0);
    chk("restante_after_63", 32'(bus.restante), 0);
    chk("scoreboard_empty",  32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
